tick_rate_sel: RTL and testbench
================================

Name: tick_rate_sel

Overview:
- Parametrised, glitch-free rate selector for the LED/shift-register datapath.
- Replaces muxing of separately divided clocks with one clock domain: internal divider, per-rate one-cycle enable `tick`, and a registered 50%-duty `phase` level.
- Rate changes are applied only on a period boundary, so downstream logic never sees a runt period.
- Optional immediate-restart mode for fast response.

Parameters:
- NUM_RATES, 4, number of selectable rates (2..4); sel codes >= NUM_RATES are illegal.
- CNT_W, 27, divider counter width; must hold max(DIVn)-1.
- DIV0, 100_000_000, period of rate 0 in clk cycles (1 Hz at 100 MHz); legal range 2..2^CNT_W.
- DIV1, 8_333_333, period of rate 1 (12 Hz).
- DIV2, 25_000_000, period of rate 2 (4 Hz).
- DIV3, 2_000_000, period of rate 3 (50 Hz).
- SWITCH_MODE, 0, 0 = switch at period boundary; 1 = switch immediately and restart the count.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  run enable; 0 = divider held cleared
- sel  input  2  requested rate code
- tick  output  1  one-cycle pulse at the end of each active period, registered
- phase  output  1  toggles on every tick, registered
- cur_sel  output  2  rate code currently in effect
- pending  output  1  1 while a legal requested rate differs from cur_sel and is not yet applied

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While rst_n=0: cnt=0, tick=0, phase=0, cur_sel=0, pending=0.
- Divider: cnt counts 0..DIV[cur_sel]-1.
  - tick is registered and asserts on the cycle after cnt==DIV[cur_sel]-1.
  - On that same edge cnt wraps to 0.
  - tick period is therefore exactly DIV[cur_sel] clk cycles.
  - The first tick after reset release (en=1) occurs in cycle DIV[0].
- Phase: phase inverts on the edge where tick is registered high, giving period 2*DIV with duty exactly 50%.
- Legal request: sel < NUM_RATES.
  - An illegal sel is ignored: no pending, cur_sel unchanged.
- SWITCH_MODE=0:
  - pending = legal sel != cur_sel, registered.
  - On a wrap edge (cnt==DIV-1), cur_sel <= sampled sel if legal, and the new period starts from cnt=0.
  - No tick is dropped or duplicated.
  - A request withdrawn before the boundary (sel returns to cur_sel) causes no switch, and pending clears next cycle.
- SWITCH_MODE=1:
  - A legal sel != cur_sel causes cur_sel <= sel and cnt <= 0 on the next edge.
  - No tick is generated on that edge.
  - phase is held.
  - pending is never asserted.
- Simultaneous wrap and sel change (mode 0): the wrap tick is still issued, and the new rate applies from the next cycle.
- en=0:
  - cnt <= 0, tick <= 0, phase held.
  - cur_sel <= sel immediately if legal; pending <= 0.
  - When en returns high, counting restarts from 0 at the selected rate.
- Reset mid-period: all state clears asynchronously; no partial tick is emitted.
- Width rules:
  - Comparisons use CNT_W-bit constants DIVn-1.
  - sel is 2 bits regardless of NUM_RATES.
  - A DIV value of 1 or below is illegal; simulation flags it at elaboration with a $error.

Test Plan:
Bench parameters for all scenarios: DIV0=4, DIV1=6, DIV2=10, DIV3=2, NUM_RATES=4.
- Reset/steady run: rst_n released, en=1, sel=0 -> tick high in cycles 4, 8, 12 (1 cycle wide); phase=1 after the first tick and 0 after the second; cur_sel=0, pending=0.
- Boundary switch (mode 0): sel 0->1 at cycle 5 -> pending=1 on cycles 6-8; tick at 8; cur_sel=1 from 9; next ticks at 14 and 20; no interval other than 4 or 6.
- Withdrawn request and illegal code: sel=2 for 1 cycle then back to 0 -> no switch, tick spacing stays 4. NUM_RATES=3 with sel=3 -> pending stays 0, cur_sel unchanged.
- Immediate mode (SWITCH_MODE=1): at cnt=2 with rate 2, sel->3 -> cur_sel=3 next cycle, cnt=0, no tick on that edge; ticks then every 2 cycles; phase unchanged at the switch.
- Enable gating: en=0 for 7 cycles mid-period with sel changed to 1 -> tick=0 throughout, phase held, cur_sel=1 immediately; after en=1, first tick 6 cycles later.
- Async reset mid-period: rst_n pulsed low between clock edges at cnt=3 -> all outputs 0 immediately with no clk edge; count resumes from 0 after release.

Source files
------------

// File: rtl/tick_rate_sel.sv
// Single-domain rate selector: divider with per-rate 1-cycle tick and 50% phase, rate switch at period boundary or immediate.
// Latency: tick/phase/cur_sel/pending registered, one cycle after the deciding edge; no backpressure (free-running, en gates).
module tick_rate_sel #(
  parameter int NUM_RATES   = 4,
  parameter int CNT_W       = 27,
  parameter int DIV0        = 100_000_000,
  parameter int DIV1        = 8_333_333,
  parameter int DIV2        = 25_000_000,
  parameter int DIV3        = 2_000_000,
  parameter int SWITCH_MODE = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [1:0] i_sel,
  output logic       o_tick,
  output logic       o_phase,
  output logic [1:0] o_cur_sel,
  output logic       o_pending
);

  if (DIV0 < 2 || DIV1 < 2 || DIV2 < 2 || DIV3 < 2) begin : g_bad_div
    $error("tick_rate_sel: every DIVn must be at least 2");
  end
  if (NUM_RATES < 2 || NUM_RATES > 4) begin : g_bad_rates
    $error("tick_rate_sel: NUM_RATES must be 2..4");
  end

  localparam logic [2:0] NR = 3'(NUM_RATES);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_phase;
  logic [1:0]       r_cur;
  logic             r_pend;

  logic [CNT_W-1:0] w_last;
  logic             w_legal;
  logic             w_wrap;
  logic             w_req;
  logic [1:0]       w_cur_nxt;

  always_comb begin
    case (r_cur)
      2'd0:    w_last = CNT_W'(DIV0 - 1);
      2'd1:    w_last = CNT_W'(DIV1 - 1);
      2'd2:    w_last = CNT_W'(DIV2 - 1);
      default: w_last = CNT_W'(DIV3 - 1);
    endcase
  end

  assign w_legal = ({1'b0, i_sel} < NR);
  assign w_wrap  = (r_cnt == w_last);
  assign w_req   = w_legal && (i_sel != r_cur);

  // Rate in effect after this edge; pending is judged against it so it drops as the switch lands.
  always_comb begin
    w_cur_nxt = r_cur;
    if (!i_en) begin
      if (w_legal) w_cur_nxt = i_sel;
    end else if (SWITCH_MODE != 0) begin
      if (w_req) w_cur_nxt = i_sel;
    end else if (w_wrap && w_legal) begin
      w_cur_nxt = i_sel;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_phase <= 1'b0;
      r_cur   <= 2'd0;
      r_pend  <= 1'b0;
    end else begin
      r_cur  <= w_cur_nxt;
      r_pend <= (SWITCH_MODE == 0) && i_en && w_legal && (i_sel != w_cur_nxt);
      if (!i_en) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if ((SWITCH_MODE != 0) && w_req) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if (w_wrap) begin
        r_cnt   <= '0;
        r_tick  <= 1'b1;
        r_phase <= ~r_phase;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
      end
    end
  end

  assign o_tick    = r_tick;
  assign o_phase   = r_phase;
  assign o_cur_sel = r_cur;
  assign o_pending = r_pend;

endmodule

// File: tb/tb_tick_rate_sel.sv
// Bench for tick_rate_sel: boundary-switch, immediate-switch and 3-rate variants against a deadline-based model.
module tb_tick_rate_sel;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] sel;

  logic       t0, p0, pd0, t1, p1, pd1, t2, p2, pd2;
  logic [1:0] c0, c1, c2;

  tick_rate_sel #(.NUM_RATES(4), .CNT_W(4), .DIV0(4), .DIV1(6), .DIV2(10), .DIV3(2), .SWITCH_MODE(0)) u_m0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sel(sel),
    .o_tick(t0), .o_phase(p0), .o_cur_sel(c0), .o_pending(pd0));
  tick_rate_sel #(.NUM_RATES(4), .CNT_W(4), .DIV0(4), .DIV1(6), .DIV2(10), .DIV3(2), .SWITCH_MODE(1)) u_m1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sel(sel),
    .o_tick(t1), .o_phase(p1), .o_cur_sel(c1), .o_pending(pd1));
  tick_rate_sel #(.NUM_RATES(3), .CNT_W(4), .DIV0(4), .DIV1(6), .DIV2(10), .DIV3(2), .SWITCH_MODE(0)) u_n3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sel(sel),
    .o_tick(t2), .o_phase(p2), .o_cur_sel(c2), .o_pending(pd2));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_edge   = 0;

  // Model: each variant remembers the edge number on which its next tick is due.
  int         div[4]  = '{4, 6, 10, 2};
  int         mode[3] = '{0, 1, 0};
  int         nr[3]   = '{4, 4, 3};
  int         m_due[3];
  logic       m_tick[3], m_phase[3], m_pend[3];
  logic [1:0] m_cur[3];

  logic [14:0] q[$];

  function automatic logic [4:0] pk(int k);
    return {m_tick[k], m_phase[k], m_cur[k], m_pend[k]};
  endfunction

  function automatic logic [14:0] actual();
    return {t0, p0, c0, pd0, t1, p1, c1, pd1, t2, p2, c2, pd2};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_tick[k] = 1'b0; m_phase[k] = 1'b0; m_pend[k] = 1'b0; m_cur[k] = 2'd0;
      m_due[k] = n_edge + div[0];
    end
  endtask

  task automatic model_edge();
    n_edge++;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit legal;
        legal = (int'(sel) < nr[k]);
        m_pend[k] = 1'b0;
        m_tick[k] = 1'b0;
        if (!en) begin
          if (legal) m_cur[k] = sel;
          m_due[k] = n_edge + div[m_cur[k]];
        end else if (mode[k] == 1 && legal && sel != m_cur[k]) begin
          m_cur[k] = sel;
          m_due[k] = n_edge + div[m_cur[k]];
        end else begin
          if (n_edge == m_due[k]) begin
            m_tick[k]  = 1'b1;
            m_phase[k] = ~m_phase[k];
            if (mode[k] == 0 && legal) m_cur[k] = sel;
            m_due[k] = n_edge + div[m_cur[k]];
          end
          m_pend[k] = (mode[k] == 0) && legal && (sel != m_cur[k]);
        end
      end
    end
    q.push_back({pk(0), pk(1), pk(2)});
  endtask

  task automatic cyc(input logic e, input logic [1:0] s);
    en  = e;
    sel = s;
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic compare(input string nm, input logic [14:0] got, input logic [14:0] exp);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got[14-5*k -: 5] !== exp[14-5*k -: 5]) begin
        failures++;
        $display("FAIL %s dut%0d edge=%0d got=%b exp=%b (tick,phase,cur2,pend)",
                 nm, k, n_edge, got[14-5*k -: 5], exp[14-5*k -: 5]);
      end
    end
  endtask

  // Reset pulse lands between edges: outputs must clear without any clock.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare("async_rst", actual(), {pk(0), pk(1), pk(2)});
    if (q.size() > 0) q[q.size()-1] = {pk(0), pk(1), pk(2)};
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    logic [14:0] e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        compare("cycle", actual(), e);
      end
    end
  end

  initial begin : stim
    logic       e;
    logic [1:0] s;
    rst_n = 1'b1;
    en    = 1'b0;
    sel   = 2'd0;
    #1 rst_n = 1'b0;
    model_reset();
    #1 compare("rst_state", actual(), {pk(0), pk(1), pk(2)});
    cyc(1'b0, 2'd0);
    cyc(1'b0, 2'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) cyc(1'b1, 2'd0);   // steady rate 0
    for (int i = 0; i < 20; i++) cyc(1'b1, 2'd1);   // boundary switch to rate 1
    for (int i = 0; i < 10; i++) cyc(1'b1, 2'd0);
    cyc(1'b1, 2'd2);                                 // withdrawn request
    for (int i = 0; i < 12; i++) cyc(1'b1, 2'd0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 2'd3);   // illegal on the 3-rate variant
    for (int i = 0; i < 12; i++) cyc(1'b1, 2'd2);
    for (int i = 0; i < 8; i++)  cyc(1'b1, 2'd3);   // immediate restart on mode 1
    for (int i = 0; i < 3; i++)  cyc(1'b1, 2'd0);
    for (int i = 0; i < 7; i++)  cyc(1'b0, 2'd1);   // enable gating
    for (int i = 0; i < 10; i++) cyc(1'b1, 2'd1);
    cyc(1'b1, 2'd0);
    cyc(1'b1, 2'd0);
    reset_pulse();
    for (int i = 0; i < 10; i++) cyc(1'b1, 2'd0);

    s = 2'd0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) reset_pulse();
      e = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 5) == 0) s = 2'($urandom_range(0, 3));
      cyc(e, s);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain leftover=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
